// File: rtl/vsd_caravel_pkg.sv
// Shared types, command codes, register addresses and reset values for the
// housekeeping SPI register block.
package vsd_caravel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA
  } spi_state_t;

  typedef enum logic [1:0] {
    MODE_NONE,
    MODE_RD,
    MODE_WR,
    MODE_RW
  } spi_mode_t;

  localparam logic [7:0] CMD_RD = 8'h40;
  localparam logic [7:0] CMD_WR = 8'h80;
  localparam logic [7:0] CMD_RW = 8'hc0;

  localparam logic [7:0] ADDR_MFGR_HI   = 8'h01;
  localparam logic [7:0] ADDR_MFGR_LO   = 8'h02;
  localparam logic [7:0] ADDR_PRODUCT   = 8'h03;
  localparam logic [7:0] ADDR_RW_FIRST  = 8'h08;
  localparam logic [7:0] ADDR_EXT_RESET = 8'h0b;
  localparam logic [7:0] ADDR_RW_LAST   = 8'h12;

  localparam int NUM_RW = 11;

  function automatic logic [7:0] rw_reset_val(input logic [7:0] addr);
    case (addr)
      8'h08:   return 8'h02;
      8'h09:   return 8'h01;
      8'h0d:   return 8'hff;
      8'h0e:   return 8'hef;
      8'h0f:   return 8'hff;
      8'h10:   return 8'h03;
      8'h11:   return 8'h12;
      8'h12:   return 8'h04;
      default: return 8'h00;
    endcase
  endfunction

  function automatic spi_mode_t decode_cmd(input logic [7:0] cmd);
    case (cmd)
      CMD_RD:  return MODE_RD;
      CMD_WR:  return MODE_WR;
      CMD_RW:  return MODE_RW;
      default: return MODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/vsd_caravel_hkspi.sv
// SPI slave: 2-flop synchronizers, SCK edge detect, CMD/ADDR/DATA sequencer.
// Read data loads on the 8th bit; write strobe fires the cycle after; no backpressure.
module vsd_caravel_hkspi
  import vsd_caravel_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       hk_sck,
  input  logic       hk_csb,
  input  logic       hk_sdi,
  output logic       hk_sdo,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_dat,
  output logic       wr_vld,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_dat
);

  logic [1:0] sck_sync, csb_sync, sdi_sync;
  logic       sck_d;
  logic       sck_rise, csb_s, sdi_s, byte_done, rd_mode, wr_mode;
  logic [2:0] bit_cnt;
  logic [7:0] in_sh, out_sh, addr, in_byte;
  spi_state_t state_q, state_d;
  spi_mode_t  mode_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync <= 2'b00;
      csb_sync <= 2'b11;
      sdi_sync <= 2'b00;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], hk_sck};
      csb_sync <= {csb_sync[0], hk_csb};
      sdi_sync <= {sdi_sync[0], hk_sdi};
      sck_d    <= sck_sync[1];
    end
  end

  assign sck_rise  = sck_sync[1] & ~sck_d;
  assign csb_s     = csb_sync[1];
  assign sdi_s     = sdi_sync[1];
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign in_byte   = {in_sh[6:0], sdi_s};
  assign rd_mode   = (mode_q == MODE_RD) || (mode_q == MODE_RW);
  assign wr_mode   = (mode_q == MODE_WR) || (mode_q == MODE_RW);

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (csb_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD:  if (byte_done) state_d = ST_ADDR;
        ST_ADDR: if (byte_done) state_d = ST_DATA;
        default: state_d = ST_DATA;
      endcase
    end
  end

  // While the address byte is arriving, look up the address being assembled;
  // afterwards pre-fetch the next address so streaming reads stay one byte ahead.
  assign rd_addr = (state_q == ST_ADDR) ? in_byte : addr + 8'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      in_sh   <= 8'h00;
      out_sh  <= 8'h00;
      addr    <= 8'h00;
      mode_q  <= MODE_NONE;
      wr_vld  <= 1'b0;
      wr_addr <= 8'h00;
      wr_dat  <= 8'h00;
    end else begin
      wr_vld <= 1'b0;
      if (csb_s || state_q == ST_IDLE) begin
        bit_cnt <= 3'd0;
        in_sh   <= 8'h00;
        out_sh  <= 8'h00;
        mode_q  <= MODE_NONE;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        in_sh   <= in_byte;
        out_sh  <= {out_sh[6:0], 1'b0};
        if (bit_cnt == 3'd7) begin
          case (state_q)
            ST_CMD: mode_q <= decode_cmd(in_byte);
            ST_ADDR: begin
              addr <= in_byte;
              if (rd_mode) out_sh <= rd_dat;
            end
            ST_DATA: begin
              addr <= addr + 8'd1;
              if (rd_mode) out_sh <= rd_dat;
              if (wr_mode) begin
                wr_vld  <= 1'b1;
                wr_addr <= addr;
                wr_dat  <= in_byte;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign hk_sdo = (state_q == ST_DATA && rd_mode) ? out_sh[7] : 1'b0;

endmodule

// File: rtl/vsd_caravel.sv
// Housekeeping register file behind the SPI slave; ext_reset mirrors reg 0x0b bit 0.
// Reads are combinational on the strobe address; writes land one cycle after the byte.
module vsd_caravel
  import vsd_caravel_pkg::*;
#(
  parameter logic [7:0]  PRODUCT_ID = 8'h11,
  parameter logic [11:0] MFGR_ID    = 12'h456
) (
  input  logic clock,
  input  logic reset,
  input  logic hk_sck,
  input  logic hk_csb,
  input  logic hk_sdi,
  output logic hk_sdo,
  output logic ext_reset
);

  logic [7:0] rd_addr, rd_dat, wr_addr, wr_dat;
  logic       wr_vld;
  logic [3:0] rd_idx, wr_idx;
  logic       rd_in_rw, wr_in_rw;
  logic [7:0] rw_q [NUM_RW];

  vsd_caravel_hkspi u_hkspi (
    .clock   (clock),
    .reset   (reset),
    .hk_sck  (hk_sck),
    .hk_csb  (hk_csb),
    .hk_sdi  (hk_sdi),
    .hk_sdo  (hk_sdo),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat),
    .wr_vld  (wr_vld),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat)
  );

  assign rd_in_rw = (rd_addr >= ADDR_RW_FIRST) && (rd_addr <= ADDR_RW_LAST);
  assign wr_in_rw = (wr_addr >= ADDR_RW_FIRST) && (wr_addr <= ADDR_RW_LAST);
  assign rd_idx   = 4'(rd_addr - ADDR_RW_FIRST);
  assign wr_idx   = 4'(wr_addr - ADDR_RW_FIRST);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= rw_reset_val(8'(ADDR_RW_FIRST + i));
    end else if (wr_vld && wr_in_rw) begin
      rw_q[wr_idx] <= (wr_addr == ADDR_EXT_RESET) ? {7'b0, wr_dat[0]} : wr_dat;
    end
  end

  always_comb begin
    rd_dat = 8'h00;
    if (rd_in_rw) begin
      rd_dat = rw_q[rd_idx];
    end else begin
      case (rd_addr)
        ADDR_MFGR_HI: rd_dat = {4'h0, MFGR_ID[11:8]};
        ADDR_MFGR_LO: rd_dat = MFGR_ID[7:0];
        ADDR_PRODUCT: rd_dat = PRODUCT_ID;
        default:      rd_dat = 8'h00;
      endcase
    end
  end

  assign ext_reset = rw_q[4'(ADDR_EXT_RESET - ADDR_RW_FIRST)][0];

endmodule

// File: tb/tb_vsd_caravel.sv
// Bit-banged SPI master checked against a byte-level register-map model.
`timescale 1ns/1ps
module tb_vsd_caravel;

  logic clock = 1'b0, reset = 1'b1;
  logic hk_sck = 1'b0, hk_csb = 1'b1, hk_sdi = 1'b0;
  logic hk_sdo, ext_reset;

  int n_tests = 0, n_fail = 0;
  logic [7:0] model [256];
  logic [7:0] tx_buf [32];
  logic [7:0] rx_buf [32];

  vsd_caravel dut (
    .clock     (clock),
    .reset     (reset),
    .hk_sck    (hk_sck),
    .hk_csb    (hk_csb),
    .hk_sdi    (hk_sdi),
    .hk_sdo    (hk_sdo),
    .ext_reset (ext_reset)
  );

  always #12.5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 256; a++) model[a] = 8'h00;
    model[8'h01] = 8'h04; model[8'h02] = 8'h56; model[8'h03] = 8'h11;
    model[8'h08] = 8'h02; model[8'h09] = 8'h01; model[8'h0d] = 8'hff;
    model[8'h0e] = 8'hef; model[8'h0f] = 8'hff; model[8'h10] = 8'h03;
    model[8'h11] = 8'h12; model[8'h12] = 8'h04;
  endtask

  task automatic model_wr(input logic [7:0] a, input logic [7:0] d);
    if (a >= 8'h08 && a <= 8'h12) model[a] = (a == 8'h0b) ? {7'b0, d[0]} : d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #100;
    reset = 1'b0;
    #100;
    model_reset();
  endtask

  // Master changes SDI while SCK is low and samples SDO just before the rising edge.
  task automatic spi_bit(input logic b, output logic r);
    hk_sck = 1'b0;
    hk_sdi = b;
    #100;
    r = hk_sdo;
    hk_sck = 1'b1;
    #100;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  task automatic spi_begin();
    hk_csb = 1'b0;
    #100;
  endtask

  task automatic spi_end();
    hk_sck = 1'b0;
    #100;
    hk_csb = 1'b1;
    #300;
  endtask

  task automatic do_txn(input logic [7:0] cmd, input logic [7:0] addr, input int n);
    logic [7:0] r, a, exp;
    logic rd, wr;
    rd = (cmd == 8'h40) || (cmd == 8'hc0);
    wr = (cmd == 8'h80) || (cmd == 8'hc0);
    spi_begin();
    spi_byte(cmd, r);
    check("sdo_during_cmd", r, 8'h00);
    spi_byte(addr, r);
    check("sdo_during_addr", r, 8'h00);
    for (int i = 0; i < n; i++) begin
      a = addr + 8'(i);
      spi_byte(tx_buf[i], rx_buf[i]);
      exp = rd ? model[a] : 8'h00;
      check($sformatf("cmd%02h_byte@%02h", cmd, a), rx_buf[i], exp);
      if (wr) model_wr(a, tx_buf[i]);
    end
    spi_end();
    check("ext_reset_after_txn", ext_reset, model[8'h0b][0]);
  endtask

  initial begin
    logic [7:0] r, cmd, addr;
    logic b;
    int n;

    #50;
    do_reset();
    check("reset_sdo", hk_sdo, 1'b0);
    check("reset_ext_reset", ext_reset, 1'b0);

    do_txn(8'h40, 8'h03, 1);
    check("product_id", rx_buf[0], 8'h11);

    tx_buf[0] = 8'h01;
    do_txn(8'h80, 8'h0b, 1);
    check("ext_reset_set", ext_reset, 1'b1);
    tx_buf[0] = 8'h00;
    do_txn(8'h80, 8'h0b, 1);
    check("ext_reset_clr", ext_reset, 1'b0);

    do_txn(8'h40, 8'h00, 19);

    tx_buf[0] = 8'ha5; tx_buf[1] = 8'h3c;
    do_txn(8'h80, 8'h0d, 2);
    do_txn(8'h40, 8'h0d, 2);
    check("rb_0d", rx_buf[0], 8'ha5);
    check("rb_0e", rx_buf[1], 8'h3c);
    tx_buf[0] = 8'h77;
    do_txn(8'h80, 8'h03, 1);
    do_txn(8'h40, 8'h03, 1);
    check("ro_03_kept", rx_buf[0], 8'h11);

    // Abort a write after 4 data bits.
    spi_begin();
    spi_byte(8'h80, r);
    spi_byte(8'h10, r);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    spi_end();
    do_txn(8'h40, 8'h10, 1);
    check("partial_no_write", rx_buf[0], 8'h03);
    tx_buf[0] = 8'h5a;
    do_txn(8'h80, 8'h10, 1);
    do_txn(8'h40, 8'h10, 1);
    check("after_abort_write", rx_buf[0], 8'h5a);

    tx_buf[0] = 8'h55;
    do_txn(8'h80, 8'h0c, 1);
    tx_buf[0] = 8'h01;
    do_txn(8'h80, 8'h0b, 1);
    do_reset();
    check("reset_ext_reset2", ext_reset, 1'b0);
    do_txn(8'h40, 8'h0c, 1);
    check("reset_0c", rx_buf[0], 8'h00);

    // Reset pulsed mid-transaction: the write must not happen.
    spi_begin();
    spi_byte(8'h80, r);
    spi_byte(8'h0c, r);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    reset = 1'b1;
    #100;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    spi_end();
    model_reset();
    do_txn(8'h40, 8'h0c, 1);
    check("midtxn_reset_0c", rx_buf[0], 8'h00);

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0: cmd = 8'h40;
        1: cmd = 8'h80;
        2: cmd = 8'hc0;
        default: cmd = 8'h20 | 8'($urandom_range(0, 15));
      endcase
      addr = ($urandom_range(0, 7) == 0) ? 8'hfe : 8'($urandom_range(0, 31));
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom());
      do_txn(cmd, addr, n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vsd_caravel.md
VSD_CARAVEL -- requirements
Module: vsd_caravel

Interface
REQ-001 SHALL have parameter PRODUCT_ID, default 8'h11, product ID returned at register 0x03.
REQ-002 SHALL have parameter MFGR_ID, default 12'h456, manufacturer ID split across registers 0x01 (upper nibble, zero-extended) and 0x02 (low byte).
REQ-003 SHALL have port clock  input  1  sole system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port hk_sck  input  1  housekeeping SPI clock, asynchronous to clock.
REQ-006 SHALL have port hk_csb  input  1  SPI chip select, active low, asynchronous.
REQ-007 SHALL have port hk_sdi  input  1  SPI serial data in, asynchronous.
REQ-008 SHALL have port hk_sdo  output  1  SPI serial data out.
REQ-009 SHALL have port ext_reset  output  1  external reset request, equal to register 0x0b bit 0.

Function
REQ-010 SHALL pass hk_sck, hk_csb and hk_sdi through 2-flop synchronizers, then detect hk_sck edges on the synchronized value.
REQ-011 SHALL sample hk_sdi, MSB first, on each detected hk_sck rising edge while CSB is low.
REQ-012 SHALL use the states IDLE -> CMD (8 bits) -> ADDR (8 bits) -> DATA (repeating 8-bit bytes).
REQ-013 SHALL return to IDLE on synchronized CSB high from any state, discard any partial byte and make no write.
REQ-014 SHALL decode the command byte as: 0x40 = read stream, 0x80 = write stream, 0xC0 = read/write stream; any other code ignores the following bytes until CSB rises.
REQ-015 SHALL, in read modes, load the register at the current address into the output shift register when the 8th address or data bit is sampled, and drive its MSB on hk_sdo within 3 clock cycles.
REQ-016 SHALL shift hk_sdo to the next bit within 3 clock cycles after each detected rising edge, holding it stable until the next rising edge.
REQ-017 SHALL, in write modes, write the assembled byte into the current address in the cycle after its 8th bit is sampled.
REQ-018 SHALL, in read/write mode, read the old register value before writing it.
REQ-019 SHALL increment the address after every completed data byte, wrapping from 0xFF to 0x00.
REQ-020 SHALL implement this register map (reset value / access):
  - 0x00: 0x00, RO
  - 0x01: {4'h0, MFGR_ID[11:8]} = 0x04, RO
  - 0x02: MFGR_ID[7:0] = 0x56, RO
  - 0x03: PRODUCT_ID = 0x11, RO
  - 0x04-0x07: 0x00, RO
  - 0x08: 0x02, RW
  - 0x09: 0x01, RW
  - 0x0a: 0x00, RW
  - 0x0b: 0x00, RW, bit 0 only; other bits read 0
  - 0x0c: 0x00, RW
  - 0x0d: 0xff, RW
  - 0x0e: 0xef, RW
  - 0x0f: 0xff, RW
  - 0x10: 0x03, RW
  - 0x11: 0x12, RW
  - 0x12: 0x04, RW
  - 0x13-0xFF: read 0x00, writes ignored
REQ-021 SHALL ignore writes to RO registers without error.
REQ-022 SHALL drive hk_sdo low when not in a read-mode DATA state.
REQ-023 SHALL apply a register write in the same cycle the SPI state machine aborts on CSB high only if the byte had completed before that cycle.

Reset
REQ-024 SHALL, on reset, force the state to IDLE, clear the shift registers and bit counter, and set the address to 0x00.
REQ-025 SHALL, on reset, load every register with its REQ-020 value, so hk_sdo = 0 and ext_reset = 0.
REQ-026 SHALL, on reset asserted mid-transaction, abort the transaction; the master must re-assert CSB.

Structure
REQ-027 SHALL place the command codes, register addresses and reset values in package vsd_caravel_pkg.
REQ-028 SHALL contain one sub-module, vsd_caravel_hkspi: synchronizers, edge detect, state machine, shift registers, address counter, with a byte read/write strobe interface.
REQ-029 SHALL keep the register file and ext_reset logic in vsd_caravel.

Verification (clock period 25 ns, SCK 100 ns low / 100 ns high)
REQ-030 SHALL check: command 0x40, address 0x03, read one byte -> 0x11.
REQ-031 SHALL check: command 0x80, address 0x0b, data 0x01 -> ext_reset = 1; then data 0x00 -> ext_reset = 0.
REQ-032 SHALL check: command 0x40, address 0x00, read 19 bytes -> 00 04 56 11 00 00 00 00 02 01 00 00 00 ff ef ff 03 12 04.
REQ-033 SHALL check: command 0x80, address 0x0d, data 0xa5 0x3c, then read back from 0x0d -> a5 3c; a write of 0x77 to 0x03 still reads 0x11.
REQ-034 SHALL check: CSB raised after 4 bits of a write data byte to 0x10 -> register stays 0x03; a new transaction works normally.
REQ-035 SHALL check: reset pulsed after a write of 0x55 to 0x0c -> register reads 0x00 and ext_reset = 0.
